// File: rtl/control_filtro_iir.sv
// Sequencer for the 200 Hz low-pass IIR datapath: five-product MAC schedule per ADC sample.
// Optional sticky overrun flag is built when OVERRUN_DET_EN is defined.
module control_filtro_iir #(
    parameter int PASO_CICLOS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bandera_adc,
    output logic [2:0] sel_const,
    output logic [1:0] sel_fun,
    output logic       sel_acum,
    output logic       en_reg,
    output logic       shift,
    output logic       clr_acum,
    output logic       band_listo,
    output logic       ocupado
`ifdef OVERRUN_DET_EN
    ,
    output logic       overrun
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        S_A1,
        S_A2,
        S_SHIFT,
        S_B0,
        S_B1,
        S_B2,
        S_DONE
    } estado_t;

    localparam logic [3:0] PASO_ULTIMO = 4'(PASO_CICLOS - 1);

    estado_t    state;
    estado_t    state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       adc_prev;
    logic       inicio;
    logic       es_mac;
    logic       paso_fin;

    assign inicio   = bandera_adc && !adc_prev;
    assign es_mac   = (state == S_A1) || (state == S_A2) || (state == S_B0) ||
                      (state == S_B1) || (state == S_B2);
    assign paso_fin = (cnt == PASO_ULTIMO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            adc_prev <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            adc_prev <= bandera_adc;
        end
    end

    // Counter only runs inside MAC states; any other state leaves it at zero.
    always_comb begin
        state_next = state;
        cnt_next   = 4'd0;
        if (es_mac && !paso_fin) begin
            cnt_next = cnt + 4'd1;
        end
        case (state)
            IDLE:    if (inicio) state_next = S_A1;
            S_A1:    if (paso_fin) state_next = S_A2;
            S_A2:    if (paso_fin) state_next = S_SHIFT;
            S_SHIFT: state_next = S_B0;
            S_B0:    if (paso_fin) state_next = S_B1;
            S_B1:    if (paso_fin) state_next = S_B2;
            S_B2:    if (paso_fin) state_next = S_DONE;
            S_DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore decode: outputs depend only on state and step counter.
    always_comb begin
        sel_const  = 3'd0;
        sel_fun    = 2'd0;
        sel_acum   = 1'b0;
        shift      = 1'b0;
        clr_acum   = 1'b0;
        band_listo = 1'b0;
        en_reg     = es_mac && paso_fin;
        ocupado    = (state != IDLE);
        case (state)
            S_A1: begin
                sel_const = 3'd0;
                sel_fun   = 2'd1;
                sel_acum  = 1'b1;
            end
            S_A2: begin
                sel_const = 3'd1;
                sel_fun   = 2'd2;
            end
            S_SHIFT: begin
                shift    = 1'b1;
                clr_acum = 1'b1;
            end
            S_B0: begin
                sel_const = 3'd2;
                sel_fun   = 2'd0;
            end
            S_B1: begin
                sel_const = 3'd3;
                sel_fun   = 2'd1;
            end
            S_B2: begin
                sel_const = 3'd4;
                sel_fun   = 2'd2;
            end
            S_DONE:  band_listo = 1'b1;
            default: ;
        endcase
    end

`ifdef OVERRUN_DET_EN
    // Sticky: a start arriving while busy is dropped but remembered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (inicio && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/control_filtro_iir.md
# control_filtro_iir

Sequencing controller for the 200 Hz low-pass IIR datapath. On each new ADC sample it steps the coefficient, state-variable and accumulator multiplexers through a fixed five-product schedule. It strobes the sum register, the state shift register and the accumulator clear at the right cycles, then pulses a completion flag. It sits between the ADC sample flag and the filter's mux/register datapath, and replaces the free-running mux control with a deterministic, stall-capable schedule.

## Interface

Parameters:
- PASO_CICLOS, 1, clock cycles each multiply-accumulate step is held (1..15); supports a multi-cycle multiplier.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- bandera_adc  in  1  ADC sample-ready flag; level may stay high for several cycles; only its rising edge matters.
- sel_const  out  3  coefficient mux select.
- sel_fun  out  2  state-variable mux select: 0=fk, 1=fk_1, 2=fk_2.
- sel_acum  out  1  adder operand select: 1=Uk, 0=accumulator feedback.
- en_reg  out  1  sum-register load enable.
- shift  out  1  state shift-register advance.
- clr_acum  out  1  synchronous accumulator clear.
- band_listo  out  1  one-cycle pulse: Yk valid.
- ocupado  out  1  high while a sample is in process.
- overrun  out  1  sticky overrun flag; present only with OVERRUN_DET_EN.

## Operation

- Edge detect: register adc_prev <= bandera_adc every cycle. A start is bandera_adc=1 with adc_prev=0.
- FSM states and the outputs in each state. Outputs are Moore, decoded from state and step counter only.
  - IDLE: all outputs 0. On start, go to S_A1 and load the step counter with 0.
  - S_A1: sel_const=0 (a1), sel_fun=1, sel_acum=1.
  - S_A2: sel_const=1 (a2), sel_fun=2, sel_acum=0. The sum register then holds the new fk.
  - S_SHIFT: shift=1, clr_acum=1. Held 1 cycle, then go to S_B0.
  - S_B0: sel_const=2, sel_fun=0, sel_acum=0.
  - S_B1: sel_const=3, sel_fun=1, sel_acum=0.
  - S_B2: sel_const=4, sel_fun=2, sel_acum=0.
  - S_DONE: band_listo=1. Held 1 cycle, then go to IDLE.
- Step counter (4 bits):
  - Each MAC state (S_A1, S_A2, S_B0..S_B2) is held PASO_CICLOS cycles.
  - en_reg=1 only in the final cycle of each MAC state. The state advances on that cycle's edge and the counter returns to 0.
- ocupado=1 in every state except IDLE.
- Starts detected in any non-IDLE state, including S_DONE, are dropped; no queuing.
- A level held high never retriggers. A new start needs bandera_adc to go low for at least one sampled cycle.
- Reset value of every output: 0. Also on reset: state=IDLE, counter=0, adc_prev=0, overrun=0.
- Reset mid-operation aborts to IDLE with no band_listo pulse.
- Because adc_prev resets to 0, bandera_adc high at reset release counts as a start at the first clock edge.

## Timing

- Start detected at clock edge k: the FSM is in S_A1 for the cycle after edge k.
- Busy length: 5·PASO_CICLOS + 2 cycles.
- band_listo is high in the last busy cycle, i.e. the cycle following edge k + 5·PASO_CICLOS + 1.
- Return to IDLE at edge k + 5·PASO_CICLOS + 2.
- With PASO_CICLOS=1:
  - en_reg high in cycles 1, 2, 4, 5, 6 after k.
  - shift and clr_acum high in cycle 3.
  - band_listo high in cycle 7.
  - Minimum start-to-start spacing is 8 cycles.
- en_reg, shift and band_listo are never high in the same cycle.

## Configuration

- OVERRUN_DET_EN defined:
  - overrun port exists.
  - overrun is set on the cycle after a start is detected while not in IDLE.
  - It stays set until reset and does not affect sequencing.
- OVERRUN_DET_EN undefined: no overrun port or logic; dropped starts are silent.

## Test plan

- Reset: assert reset mid-clock with bandera_adc=0 -> all outputs 0 immediately and while reset is held; FSM in IDLE.
- Single sample, PASO_CICLOS=1: pulse bandera_adc high 1 cycle -> sel_const sequence 0,1,x,2,3,4 and sel_fun sequence 1,2,x,0,1,2. en_reg high in cycles 1,2,4,5,6; shift/clr_acum in cycle 3; band_listo in cycle 7; ocupado high cycles 1-7.
- Level hold: bandera_adc held high 20 cycles -> exactly one band_listo; none after the FSM returns to IDLE.
- PASO_CICLOS=3: single start -> each MAC state lasts 3 cycles with en_reg only in its 3rd cycle; band_listo in cycle 17; busy 17 cycles.
- Overrun (macro defined, PASO_CICLOS=1): second rising edge 4 cycles after the first -> one band_listo only; overrun rises in the cycle after the second edge and stays 1 until reset.
- Reset mid-operation: assert reset in S_B0 -> outputs 0 asynchronously, no band_listo. After release, a new edge completes a normal 7-cycle sequence.
